// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC sequencing, redirect/fault handling and a small
// fetch queue that decouples single-cycle instruction memory from decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_cs,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             fault_q, fault_d;

  logic [31:0]      q_pc    [QDEPTH];
  logic [31:0]      q_instr [QDEPTH];

  logic             redir_c;
  logic             misalign_c;
  logic             fetch_c;
  logic             deq_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (misalign_c) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode; reset masks visible outputs in the reset cycle itself
  always_comb begin
    redir_c    = 1'b0;
    misalign_c = 1'b0;
    fetch_c    = 1'b0;
    imem_cs    = 1'b0;
    imem_addr  = pc_q;
    out_valid  = 1'b0;
    out_pc     = 32'h0;
    out_instr  = 32'h0;
    deq_c      = 1'b0;
    if (state_q == FETCH) begin
      redir_c    = redirect_valid;
      misalign_c = redirect_valid && (redirect_pc[1:0] != 2'b00);
      fetch_c    = !redirect_valid &&
                   ((count_q < FULL) || ((count_q == FULL) && out_ready));
    end
    imem_cs   = fetch_c && !reset;
    out_valid = (count_q != '0) && (state_q != FAULT) && !reset;
    if (out_valid) begin
      out_pc    = q_pc[rd_ptr_q];
      out_instr = q_instr[rd_ptr_q];
    end
    deq_c       = out_valid && out_ready && !redir_c;
    fetch_fault = fault_q && !reset;
  end

  // Datapath next-state: redirect flushes the queue and beats any enqueue/dequeue
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fault_d  = fault_q;
    if (state_q == IDLE) begin
      pc_d = RESET_PC;
    end else if (redir_c) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (misalign_c) begin
        fault_d = 1'b1;
      end else begin
        pc_d = redirect_pc;
      end
    end else begin
      if (fetch_c) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
      end
      if (deq_c) begin
        rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
      end
      count_d = CNT_W'(count_q + CNT_W'(fetch_c) - CNT_W'(deq_c));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fault_q  <= fault_d;
    end
  end

  // Queue storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (fetch_c) begin
      q_pc[wr_ptr_q]    <= pc_q;
      q_instr[wr_ptr_q] <= imem_instr;
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, the fetch queue depth in entries; legal values are powers of two, 2 or greater.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_cs, output, 1 bit: instruction memory chip select.
REQ-006 SHALL have port imem_addr, output, 32 bits: byte address to instruction memory; bits [1:0] always 0.
REQ-007 SHALL have port imem_instr, input, 32 bits: memory read data, combinationally valid in the same cycle as imem_cs/imem_addr.
REQ-008 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-009 SHALL have port redirect_pc, input, 32 bits: redirect target byte address.
REQ-010 SHALL have port out_valid, output, 1 bit: queue head holds a valid instruction.
REQ-011 SHALL have port out_instr, output, 32 bits: instruction at queue head.
REQ-012 SHALL have port out_pc, output, 32 bits: PC of instruction at queue head.
REQ-013 SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-014 SHALL have port fetch_fault, output, 1 bit: sticky misaligned-redirect flag.

Function
REQ-015 SHALL implement the FSM states IDLE, FETCH and FAULT; reset enters IDLE; IDLE goes to FETCH unconditionally on the next cycle; FAULT exits only on reset.
REQ-016 SHALL hold the PC register at RESET_PC in IDLE.
REQ-017 SHALL, in FETCH, assert imem_cs=1 with imem_addr=pc exactly when redirect_valid=0 and (count<QDEPTH, or count==QDEPTH with out_ready=1); otherwise imem_cs=0 and imem_addr=pc.
REQ-018 SHALL, on a fetch cycle, enqueue {pc, imem_instr} at the clock edge and set pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 SHALL assert out_valid exactly when count>0, with out_instr/out_pc driven from the head entry; out_instr/out_pc SHALL be 0 when out_valid=0.
REQ-020 SHALL dequeue on out_valid && out_ready; simultaneous enqueue and dequeue SHALL leave count unchanged; count SHALL never exceed QDEPTH nor underflow.
REQ-021 SHALL fetch in the same cycle that the first decode request can be served: latency from fetch cycle to out_valid is 1 cycle with an empty queue; there is no combinational path from imem_instr to out_instr.
REQ-022 SHALL give redirect_valid=1 priority over all other events in FETCH: flush the queue (count<=0, entries discarded regardless of out_ready), drive imem_cs=0, and set pc<=redirect_pc; fetching resumes the following cycle.
REQ-023 SHALL, for a redirect with redirect_pc[1:0]!=0, flush the queue, leave pc unchanged, enter FAULT, and set fetch_fault<=1.
REQ-024 SHALL, in FAULT, hold imem_cs=0 and out_valid=0, and ignore redirect_valid.
REQ-025 SHALL ignore redirect_valid in IDLE.
REQ-026 SHALL drive imem_cs=0 whenever state is not FETCH.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, set state=IDLE, pc=RESET_PC, count=0, queue pointers=0, and fetch_fault=0, overriding any concurrent redirect, enqueue or dequeue.
REQ-028 SHALL hold imem_cs=0, out_valid=0, out_instr=0, out_pc=0 and fetch_fault=0 during and for the first cycle after reset, including reset asserted mid-stream with a full queue.

Verification
REQ-029 SHALL be verified by a straight-line stream: reset, memory word k=0x1000+k, out_ready=1 -> out_pc 0,4,8,... with out_instr 0x1000,0x1001,... one per cycle, first out_valid two cycles after reset deasserts.
REQ-030 SHALL be verified by backpressure: out_ready=0 for 5 cycles -> two entries (pc 0,4) held, imem_cs=0 once full; raising out_ready -> 0,4,8 delivered in order with no loss or duplication.
REQ-031 SHALL be verified by a redirect with a full queue: redirect_valid=1, redirect_pc=0x40 -> out_valid=0 the next cycle, queued entries discarded, next out_pc=0x40.
REQ-032 SHALL be verified by a misaligned redirect: redirect_pc=0x42 -> fetch_fault=1 and imem_cs=0 held indefinitely; a later aligned redirect is ignored; reset clears fetch_fault.
REQ-033 SHALL be verified by wrap-around: RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 SHALL be verified by a simultaneous full queue, out_ready=1 and fetch: count stays 2, one entry in and one out per cycle for 10 cycles.
